mux2_round_robin_selector: RTL and testbench

MUX2_ROUND_ROBIN_SELECTOR -- requirements
Module: mux2_round_robin_selector

---
 rtl/mux2_round_robin_selector.sv | 103 ++++++++++
 tb/tb_mux2_round_robin_selector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux2_round_robin_selector.sv
// Two-channel round-robin arbiter driving the select of a downstream 2-to-1 mux.
// A channel keeps the grant for at most MAX_CYCLES cycles while the other channel waits.
module mux2_round_robin_selector #(
  parameter int unsigned MAX_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_bar,
  input  logic [1:0] request,
  output logic [1:0] grant,
  output logic       selection,
  output logic       busy,
  output logic [7:0] grant_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;
  localparam logic [7:0] MAX_CNT = 8'(MAX_CYCLES);

  logic [1:0] r_state;
  logic [1:0] r_grant;
  logic       r_selection;
  logic       r_busy;
  logic [7:0] r_grant_count;
  logic       r_last_served;

  logic [1:0] w_next_state;
  logic       w_enter_grant;
  logic [7:0] w_next_count;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        case (request)
          2'b01:   w_next_state = GRANT0;
          2'b10:   w_next_state = GRANT1;
          2'b11:   w_next_state = r_last_served ? GRANT0 : GRANT1;
          default: w_next_state = IDLE;
        endcase
      end
      GRANT0: begin
        if (request[0] && (!request[1] || (r_grant_count < MAX_CNT)))
          w_next_state = GRANT0;
        else if (request[1])
          w_next_state = GRANT1;
        else
          w_next_state = IDLE;
      end
      GRANT1: begin
        if (request[1] && (!request[0] || (r_grant_count < MAX_CNT)))
          w_next_state = GRANT1;
        else if (request[0])
          w_next_state = GRANT0;
        else
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Any change of state that does not land in IDLE is a fresh grant.
  assign w_enter_grant = (w_next_state != r_state) && (w_next_state != IDLE);

  always_comb begin
    w_next_count = r_grant_count;
    if (w_next_state == IDLE)
      w_next_count = 8'd0;
    else if (w_enter_grant)
      w_next_count = 8'd1;
    else if (r_grant_count < MAX_CNT)
      w_next_count = r_grant_count + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state       <= IDLE;
      r_grant       <= 2'b00;
      r_selection   <= 1'b0;
      r_busy        <= 1'b0;
      r_grant_count <= 8'd0;
      r_last_served <= 1'b1;
    end else begin
      r_state       <= w_next_state;
      r_grant       <= {w_next_state == GRANT1, w_next_state == GRANT0};
      r_busy        <= (w_next_state != IDLE);
      r_grant_count <= w_next_count;
      // selection holds in IDLE so the mux stays on the last channel
      if (w_enter_grant) begin
        r_last_served <= (w_next_state == GRANT1);
        r_selection   <= (w_next_state == GRANT1);
      end
    end
  end

  assign grant       = r_grant;
  assign selection   = r_selection;
  assign busy        = r_busy;
  assign grant_count = r_grant_count;

endmodule

// File: tb/tb_mux2_round_robin_selector.sv
// Scoreboard bench for mux2_round_robin_selector: directed scenarios with literal
// expectations, then random traffic checked against an ownership model.
module tb_mux2_round_robin_selector;

  localparam int MAXC = 4;

  logic       clock;
  logic       reset_bar;
  logic [1:0] request;
  logic [1:0] grant;
  logic       selection;
  logic       busy;
  logic [7:0] grant_count;

  logic [1:0] req1;
  logic [1:0] grant1;
  logic       selection1;
  logic       busy1;
  logic [7:0] grant_count1;

  mux2_round_robin_selector #(.MAX_CYCLES(MAXC)) u_dut (
    .clock(clock), .reset_bar(reset_bar), .request(request),
    .grant(grant), .selection(selection), .busy(busy), .grant_count(grant_count)
  );

  mux2_round_robin_selector #(.MAX_CYCLES(1)) u_dut1 (
    .clock(clock), .reset_bar(reset_bar), .request(req1),
    .grant(grant1), .selection(selection1), .busy(busy1), .grant_count(grant_count1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] grant;
    logic       sel;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the mux, for how long, and who was served last.
  int m_owner;
  int m_cnt;
  int m_last;
  int m_sel;
  int wait_cnt[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = 1; m_sel = 0;
    wait_cnt[0] = 0; wait_cnt[1] = 0;
    q.delete();
  endtask

  task automatic model_step(input logic [1:0] r, output exp_t e);
    bit keep;
    keep = (m_owner >= 0) && r[m_owner] && (!r[1-m_owner] || m_cnt < MAXC);
    if (keep) begin
      m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
    end else if (r == 2'b00) begin
      m_owner = -1; m_cnt = 0;
    end else begin
      // a tie goes to whoever was not served last
      m_owner = (r == 2'b11) ? 1 - m_last : (r[1] ? 1 : 0);
      m_cnt = 1; m_last = m_owner; m_sel = m_owner;
    end
    e.grant = (m_owner < 0) ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01);
    e.sel   = m_sel[0];
    e.busy  = (m_owner >= 0);
    e.cnt   = 8'(m_cnt);
  endtask

  task automatic drive(input logic [1:0] r);
    exp_t e;
    @(negedge clock);
    request = r;
    model_step(r, e);
    q.push_back(e);
  endtask

  task automatic drive_exp(input logic [1:0] r, input logic [1:0] g, input int c, input logic s);
    exp_t e;
    @(negedge clock);
    request = r;
    model_step(r, e);
    e.grant = g; e.cnt = 8'(c); e.sel = s; e.busy = (g != 2'b00);
    q.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_bar = 1'b0;
    request   = 2'b00;
    req1      = 2'b00;
    model_reset();
    @(negedge clock);
    #1 reset_bar = 1'b1;
  endtask

  always @(posedge clock) begin
    #1;
    if (reset_bar && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("grant", 32'(grant), 32'(e.grant));
      check("selection", 32'(selection), 32'(e.sel));
      check("busy", 32'(busy), 32'(e.busy));
      check("grant_count", 32'(grant_count), 32'(e.cnt));
      for (int j = 0; j < 2; j++) begin
        if (request[j] && grant[1-j]) begin
          wait_cnt[j]++;
          check($sformatf("wait_ch%0d", j), 32'(wait_cnt[j] <= MAXC), 32'd1);
        end else begin
          wait_cnt[j] = 0;
        end
      end
    end
  end

  initial begin
    logic [1:0] r;
    reset_bar = 1'b0;
    request   = 2'b00;
    req1      = 2'b00;
    model_reset();
    @(posedge clock);
    #3;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_selection", 32'(selection), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(grant_count), 32'd0);
    @(negedge clock);
    #1 reset_bar = 1'b1;

    // Both requesting: four cycles each, channel 0 first.
    for (int i = 0; i < 9; i++)
      drive_exp(2'b11, ((i / 4) % 2) ? 2'b10 : 2'b01, (i % 4) + 1, ((i / 4) % 2) ? 1'b1 : 1'b0);
    drive(2'b00);

    // Single requester holds indefinitely with saturating count.
    apply_reset();
    for (int i = 0; i < 10; i++)
      drive_exp(2'b01, 2'b01, (i < 4) ? i + 1 : 4, 1'b0);

    // Handover mid-grant, then idle keeps the last selection.
    apply_reset();
    drive_exp(2'b01, 2'b01, 1, 1'b0);
    drive_exp(2'b01, 2'b01, 2, 1'b0);
    drive_exp(2'b10, 2'b10, 1, 1'b1);
    drive_exp(2'b00, 2'b00, 0, 1'b1);
    drive_exp(2'b00, 2'b00, 0, 1'b1);

    // Asynchronous reset during GRANT1.
    drive_exp(2'b10, 2'b10, 1, 1'b1);
    @(negedge clock);
    #2 reset_bar = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_selection", 32'(selection), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_count", 32'(grant_count), 32'd0);
    request = 2'b00;
    model_reset();
    @(negedge clock);
    #1 reset_bar = 1'b1;
    drive_exp(2'b11, 2'b01, 1, 1'b0);
    drive(2'b00);

    // MAX_CYCLES=1 instance alternates every cycle.
    apply_reset();
    @(negedge clock);
    req1 = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      check("mc1_grant", 32'(grant1), (i % 2) ? 32'd2 : 32'd1);
      check("mc1_count", 32'(grant_count1), 32'd1);
    end
    @(negedge clock);
    req1 = 2'b00;

    // Random traffic with sticky requests so long contention happens.
    apply_reset();
    r = 2'b00;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 2'($urandom_range(0, 3));
      drive(r);
    end
    drive(2'b00);
    @(negedge clock);
    @(negedge clock);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
